// File: rtl/wsn_radio_tx_pkg.sv
// Purpose: state encoding, framing constants and the CRC-8 bit-step helper for wsn_radio_tx.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package wsn_radio_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_LEN  = 3'd3;
    localparam logic [2:0] ST_PAY  = 3'd4;
    localparam logic [2:0] ST_CRC  = 3'd5;
    localparam logic [2:0] ST_FIN  = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRE    = ST_PRE,
        SFD_ST = ST_SFD,
        LEN_ST = ST_LEN,
        PAY    = ST_PAY,
        CRC_ST = ST_CRC,
        FIN    = ST_FIN
    } tx_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0] CRC8_POLY     = 8'h07;
    localparam logic [7:0] CRC8_INIT     = 8'h00;

    // One CRC-8 step for a single incoming bit (non-reflected shift register).
    function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/wsn_radio_tx_if.sv
// Purpose: CPU-side payload handshake, status and antenna output/enable pair of wsn_radio_tx.
// Latency: not applicable (signal bundle only).
// Backpressure: data_ready is asserted by the transmitter only when it takes a payload byte.
interface wsn_radio_tx_if;
    logic       start;
    logic [7:0] len;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       ant_o;
    logic       ant_oe;

    modport master (
        output start, len, data, data_valid,
        input  data_ready, busy, done, err, ant_o, ant_oe
    );

    modport slave (
        input  start, len, data, data_valid,
        output data_ready, busy, done, err, ant_o, ant_oe
    );
endinterface

// File: rtl/wsn_crc8.sv
// Purpose: bit-serial CRC-8 (poly 0x07, init 0x00) with synchronous clear and bit enable.
// Latency: crc_o is combinational and already includes the bit presented while en_i=1.
// Backpressure: none; a bit is absorbed on every clock with en_i=1.
module wsn_crc8
    import wsn_radio_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Look-ahead value so the caller can load the finished CRC on the same edge as the last bit.
    always_comb begin
        crc_o = en_i ? crc8_bit(crc_q, bit_i) : crc_q;
        crc_d = clr_i ? CRC8_INIT : crc_o;
    end

    // CRC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/wsn_radio_tx.sv
// Purpose: frames preamble/SFD/len/payload[/CRC-8 when WSN_TX_CRC_EN is defined] into LSB-first NRZ on ant_o/ant_oe.
// Latency: first bit on the cycle after start is sampled; done (PRE_BYTES+2+len[+1])*8*BIT_CLKS+1 cycles after start.
// Backpressure: payload pulled via data_ready on byte boundaries; data_valid low there aborts the frame with err.
module wsn_radio_tx
    import wsn_radio_pkg::*;
#(
    parameter int         BIT_CLKS  = 16,
    parameter int         PRE_BYTES = 4,
    parameter logic [7:0] SFD       = 8'hD5
) (
    input  logic clk,
    input  logic reset,
    wsn_radio_tx_if.slave tx_if
);

    localparam int              CW        = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0]   CLK_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [7:0]      PRE_LAST  = 8'(PRE_BYTES - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sh_q, sh_d;
    logic          ant_o_q, ant_o_d;
    logic          ant_oe_q, ant_oe_d;
    logic          err_q, err_d;

    logic          bit_end;
    logic          byte_end;
    logic          more_pay;
    logic          data_ready;
    logic          load;
    logic [7:0]    nxt_byte;

`ifdef WSN_TX_CRC_EN
    logic          crc_clr;
    logic          crc_en;
    logic [7:0]    crc_val;

    // Clear on every accepted start; absorb each len/payload bit on its last cycle.
    assign crc_clr = (state_q == IDLE) && tx_if.start;
    assign crc_en  = bit_end && ((state_q == LEN_ST) || (state_q == PAY));

    wsn_crc8 u_crc8 (
        .clk   (clk),
        .reset (reset),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (ant_o_q),
        .crc_o (crc_val)
    );
`endif

    assign bit_end    = (clk_cnt_q == CLK_LAST);
    assign byte_end   = bit_end && (bit_cnt_q == 3'd7);
    // In LEN_ST the remaining count is len itself; in PAY it is the bytes left after the current one.
    assign more_pay   = (state_q == LEN_ST) ? (len_q != 8'd0) : (byte_cnt_q != 8'd0);
    assign data_ready = byte_end && ((state_q == LEN_ST) || (state_q == PAY)) && more_pay;

    assign tx_if.data_ready = data_ready;
    assign tx_if.busy       = (state_q != IDLE) && (state_q != FIN);
    assign tx_if.done       = (state_q == FIN);
    assign tx_if.err        = err_q;
    assign tx_if.ant_o      = ant_o_q;
    assign tx_if.ant_oe     = ant_oe_q;

    // Framing FSM, bit/byte timing and next-byte selection.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        sh_d       = sh_q;
        ant_o_d    = ant_o_q;
        ant_oe_d   = ant_oe_q;
        err_d      = err_q;
        load       = 1'b0;
        nxt_byte   = 8'h00;

        case (state_q)
            IDLE: begin
                if (tx_if.start) begin
                    state_d    = PRE;
                    len_d      = tx_if.len;
                    err_d      = 1'b0;
                    clk_cnt_d  = '0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 8'd0;
                    ant_oe_d   = 1'b1;
                    load       = 1'b1;
                    nxt_byte   = PREAMBLE_BYTE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                if (!bit_end) begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end else begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        sh_d      = {1'b0, sh_q[7:1]};
                        ant_o_d   = sh_q[1];
                    end else begin
                        bit_cnt_d = 3'd0;
                        case (state_q)
                            PRE: begin
                                load = 1'b1;
                                if (byte_cnt_q == PRE_LAST) begin
                                    state_d  = SFD_ST;
                                    nxt_byte = SFD;
                                end else begin
                                    byte_cnt_d = byte_cnt_q + 8'd1;
                                    nxt_byte   = PREAMBLE_BYTE;
                                end
                            end
                            SFD_ST: begin
                                state_d  = LEN_ST;
                                load     = 1'b1;
                                nxt_byte = len_q;
                            end
                            LEN_ST, PAY: begin
                                if (more_pay) begin
                                    if (tx_if.data_valid) begin
                                        state_d    = PAY;
                                        load       = 1'b1;
                                        nxt_byte   = tx_if.data;
                                        byte_cnt_d = (state_q == LEN_ST) ? (len_q - 8'd1)
                                                                         : (byte_cnt_q - 8'd1);
                                    end else begin
                                        // Underrun: truncate the frame, never append a CRC.
                                        err_d   = 1'b1;
                                        state_d = FIN;
                                    end
                                end else begin
`ifdef WSN_TX_CRC_EN
                                    state_d  = CRC_ST;
                                    load     = 1'b1;
                                    nxt_byte = crc_val;
`else
                                    state_d  = FIN;
`endif
                                end
                            end
                            default: begin
                                state_d = FIN;
                            end
                        endcase
                    end
                end
            end
        endcase

        if (load) begin
            sh_d    = nxt_byte;
            ant_o_d = nxt_byte[0];
        end
        // Release the wire on entry to FIN so the pair is already idle while done is high.
        if (state_d == FIN) begin
            ant_oe_d = 1'b0;
            ant_o_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            len_q      <= 8'd0;
            sh_q       <= 8'd0;
            ant_o_q    <= 1'b0;
            ant_oe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            sh_q       <= sh_d;
            ant_o_q    <= ant_o_d;
            ant_oe_q   <= ant_oe_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/wsn_radio_tx.md
Name: wsn_radio_tx

Overview:
Framing transmitter that turns CPU-supplied payload bytes into a serial on-air bit stream for the shared antenna wire between SoC nodes. It sits directly upstream of the antenna net inside each node and drives it through an output/enable pair; the node top resolves the pair onto the shared tri-state wire. It builds each frame as preamble, start-of-frame delimiter, length and payload, serialises it LSB-first in NRZ at a programmable bit period, and releases the wire when it is idle.

Parameters:
BIT_CLKS, 16, clock cycles per transmitted bit (>=2)
PRE_BYTES, 4, number of 0xAA preamble bytes (>=1)
SFD, 8'hD5, start-of-frame delimiter byte

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  frame request, sampled only in IDLE
len  in  8  payload byte count, captured with start
data  in  8  next payload byte
data_valid  in  1  data is available
data_ready  out  1  block is consuming data this cycle
busy  out  1  frame in progress
done  out  1  one-cycle pulse when the frame completes or aborts
err  out  1  set on payload underrun; cleared by the next accepted start
ant_o  out  1  serial bit value
ant_oe  out  1  antenna drive enable

Behaviour:
- Reset (async, immediate, including mid-frame): state=IDLE; ant_oe=0, ant_o=0, busy=0, done=0, err=0, data_ready=0; all counters 0.
- States: IDLE -> PRE -> SFD_ST -> LEN_ST -> PAY -> [CRC_ST] -> FIN -> IDLE.
- IDLE: on posedge with start=1, capture len, clear err, go to PRE. From the next cycle: busy=1, ant_oe=1, ant_o = bit0 of 0xAA.
- Bit timing: clk_cnt counts 0..BIT_CLKS-1 and each bit holds for BIT_CLKS cycles. bit_cnt counts 0..7 and the shift register is LSB-first.
- Byte boundary: the last cycle of bit 7 (clk_cnt=BIT_CLKS-1, bit_cnt=7).
- PRE sends PRE_BYTES bytes of 0xAA, then SFD, then len.
- After LEN_ST: len=0 goes straight to FIN (or CRC_ST if enabled); otherwise go to PAY.
- Payload fetch, combinational: data_ready=1 only on the byte boundary where the next byte to send is payload (end of LEN_ST, or end of a payload byte with bytes remaining). data is accepted when data_valid and data_ready are both 1.
- Underrun: data_valid=0 while data_ready=1 sets err=1 and goes to FIN immediately; the frame is truncated and no CRC is sent.
- FIN lasts one cycle: ant_oe=0, ant_o=0, done=1, busy=0, then IDLE.
- Total frame duration from start sample to done: (PRE_BYTES+2+len[+1])*8*BIT_CLKS + 1 cycles.
- start while busy is ignored, with no queueing. start in the same cycle as done (FIN) is ignored.
- data and data_valid outside data_ready cycles are ignored.
- ant_o is registered and glitch-free, and changes only at bit boundaries.
- len is held internally. Changes on the len port mid-frame have no effect.

Optional Feature:
WSN_TX_CRC_EN
- Defined: CRC_ST appends one CRC-8 byte (poly 0x07, init 0x00, no reflection, no final XOR) computed over the len byte and the payload bytes. The CRC updates bitwise in the transmitted (LSB-first) bit order and is sent LSB-first. Frame length grows by 8*BIT_CLKS cycles.
- Undefined: CRC_ST and the CRC register are absent, and the frame ends after the payload.

Decomposition:
- Package wsn_radio_pkg holds: state encoding localparams, PREAMBLE_BYTE=8'hAA, CRC8_POLY=8'h07, CRC8_INIT=8'h00.
- One sub-module, wsn_crc8: bit-serial CRC-8 with clear, enable and bit-in inputs. It is instantiated only under WSN_TX_CRC_EN.

Test Plan:
1. BIT_CLKS=4, PRE_BYTES=2, len=2, bytes 0x12,0x34, data_valid held 1, CRC off -> sampled bits are AA AA D5 02 12 34 LSB-first; exactly 2 data_ready pulses; done 193 cycles after start is sampled; err=0.
2. Same as 1 with WSN_TX_CRC_EN -> 7 bytes sent; the last byte equals the bench CRC-8 model over {02,12,34}; done at cycle 225.
3. len=0 -> AA AA D5 00 sent; data_ready never asserts; done at cycle 129.
4. len=3 with data_valid dropped before the 2nd byte -> the first payload byte is sent fully; FIN follows the second data_ready cycle; err=1, done=1, ant_oe=0; the next start clears err.
5. start pulsed again mid-frame and in the FIN cycle -> both are ignored; exactly one frame is observed.
6. reset asserted mid-payload (async, between clock edges) -> ant_oe, busy and data_ready go to 0 without waiting for a clock edge; after release a fresh start produces a complete, correct frame.
